// File: rtl/stream_mux_demux.sv
// Registered stream mux/demux. The mux half merges CHANNELS streams with round-robin
// arbitration. The demux half routes one stream to the channel named by its select.
module stream_mux_demux #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*CHANNELS-1:0] mux_in_data,
  input  logic [CHANNELS-1:0]       mux_in_valid,
  output logic [CHANNELS-1:0]       mux_in_ready,
  output logic [WIDTH-1:0]          mux_out_data,
  output logic [SELW-1:0]           mux_out_chan,
  output logic                      mux_out_valid,
  input  logic                      mux_out_ready,
  input  logic [WIDTH-1:0]          demux_in_data,
  input  logic [SELW-1:0]           demux_in_sel,
  input  logic                      demux_in_valid,
  output logic                      demux_in_ready,
  output logic [WIDTH*CHANNELS-1:0] demux_out_data,
  output logic [CHANNELS-1:0]       demux_out_valid,
  input  logic [CHANNELS-1:0]       demux_out_ready,
  output logic                      demux_err
);

  // ---------------- mux half ----------------
  logic [WIDTH-1:0] in_slice [CHANNELS];
  logic [WIDTH-1:0] mux_data_q, mux_data_d;
  logic [SELW-1:0]  mux_chan_q, mux_chan_d;
  logic [SELW-1:0]  last_q, last_d;
  logic             mux_valid_q, mux_valid_d;
  logic [SELW-1:0]  grant_c, cand_c;
  logic             any_valid_c, mux_load_c;

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_slice
    assign in_slice[i] = mux_in_data[i*WIDTH +: WIDTH];
  end

  // Search last+1 .. last (wrapping modulo CHANNELS) for the first valid channel.
  always_comb begin : p_grant
    any_valid_c = 1'b0;
    grant_c     = '0;
    cand_c      = '0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      cand_c = SELW'((32'(last_q) + k) % CHANNELS);
      if (!any_valid_c && mux_in_valid[cand_c]) begin
        any_valid_c = 1'b1;
        grant_c     = cand_c;
      end
    end
  end

  assign mux_load_c   = !mux_valid_q || mux_out_ready;
  assign mux_in_ready = (!rst && mux_load_c && any_valid_c) ? (CHANNELS'(1) << grant_c) : '0;

  always_comb begin : p_mux_next
    mux_data_d  = mux_data_q;
    mux_chan_d  = mux_chan_q;
    mux_valid_d = mux_valid_q;
    last_d      = last_q;
    if (mux_load_c) begin
      mux_valid_d = any_valid_c;
      if (any_valid_c) begin
        mux_data_d = in_slice[grant_c];
        mux_chan_d = grant_c;
        last_d     = grant_c;
      end
    end
  end

  // last resets to CHANNELS-1 so channel 0 wins the first arbitration.
  always_ff @(posedge clk) begin : p_mux_reg
    if (rst) begin
      mux_data_q  <= '0;
      mux_chan_q  <= '0;
      mux_valid_q <= 1'b0;
      last_q      <= SELW'(CHANNELS - 1);
    end else begin
      mux_data_q  <= mux_data_d;
      mux_chan_q  <= mux_chan_d;
      mux_valid_q <= mux_valid_d;
      last_q      <= last_d;
    end
  end

  assign mux_out_data  = mux_data_q;
  assign mux_out_chan  = mux_chan_q;
  assign mux_out_valid = mux_valid_q;

  // ---------------- demux half ----------------
  logic [WIDTH-1:0] dmx_data_q, dmx_data_d;
  logic [SELW-1:0]  dest_q, dest_d;
  logic             held_q, held_d;
  logic             err_q, err_d;
  logic             sel_ok_c, dmx_drain_c, dmx_xfer_c;

  assign sel_ok_c       = 32'(demux_in_sel) < CHANNELS;
  assign dmx_drain_c    = held_q && demux_out_ready[dest_q];
  assign demux_in_ready = !rst && (!held_q || demux_out_ready[dest_q]);
  assign dmx_xfer_c     = demux_in_valid && demux_in_ready;

  // Out-of-range words are consumed and dropped; they only raise the sticky error.
  always_comb begin : p_dmx_next
    dmx_data_d = dmx_data_q;
    dest_d     = dest_q;
    held_d     = held_q;
    err_d      = err_q;
    if (dmx_xfer_c && sel_ok_c) begin
      dmx_data_d = demux_in_data;
      dest_d     = demux_in_sel;
      held_d     = 1'b1;
    end else if (dmx_drain_c) begin
      held_d     = 1'b0;
    end
    if (dmx_xfer_c && !sel_ok_c) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin : p_dmx_reg
    if (rst) begin
      dmx_data_q <= '0;
      dest_q     <= '0;
      held_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dmx_data_q <= dmx_data_d;
      dest_q     <= dest_d;
      held_q     <= held_d;
      err_q      <= err_d;
    end
  end

  assign demux_out_valid = held_q ? (CHANNELS'(1) << dest_q) : '0;
  assign demux_out_data  = {CHANNELS{dmx_data_q}};
  assign demux_err       = err_q;

endmodule

// File: tb/tb_stream_mux_demux.sv
// Scoreboard bench for stream_mux_demux: a 4-channel and a 3-channel instance side by side.
module tb_stream_mux_demux;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  logic clk, rst;

  logic [127:0] m4_in_data;
  logic [3:0]   m4_in_valid, m4_in_ready;
  logic [31:0]  m4_out_data;
  logic [1:0]   m4_out_chan;
  logic         m4_out_valid, m4_out_ready;
  logic [31:0]  d4_in_data;
  logic [1:0]   d4_in_sel;
  logic         d4_in_valid, d4_in_ready;
  logic [127:0] d4_out_data;
  logic [3:0]   d4_out_valid, d4_out_ready;
  logic         d4_err;

  logic [95:0]  m3_in_data;
  logic [2:0]   m3_in_valid, m3_in_ready;
  logic [31:0]  m3_out_data;
  logic [1:0]   m3_out_chan;
  logic         m3_out_valid, m3_out_ready;
  logic [31:0]  d3_in_data;
  logic [1:0]   d3_in_sel;
  logic         d3_in_valid, d3_in_ready;
  logic [95:0]  d3_out_data;
  logic [2:0]   d3_out_valid, d3_out_ready;
  logic         d3_err;

  int checks   = 0;
  int failures = 0;
  exp_t mux_q[$];
  exp_t dmx_q[$];

  stream_mux_demux #(.WIDTH(32), .CHANNELS(4)) dut4 (
    .clk(clk), .rst(rst),
    .mux_in_data(m4_in_data), .mux_in_valid(m4_in_valid), .mux_in_ready(m4_in_ready),
    .mux_out_data(m4_out_data), .mux_out_chan(m4_out_chan), .mux_out_valid(m4_out_valid),
    .mux_out_ready(m4_out_ready),
    .demux_in_data(d4_in_data), .demux_in_sel(d4_in_sel), .demux_in_valid(d4_in_valid),
    .demux_in_ready(d4_in_ready), .demux_out_data(d4_out_data), .demux_out_valid(d4_out_valid),
    .demux_out_ready(d4_out_ready), .demux_err(d4_err)
  );

  stream_mux_demux #(.WIDTH(32), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst),
    .mux_in_data(m3_in_data), .mux_in_valid(m3_in_valid), .mux_in_ready(m3_in_ready),
    .mux_out_data(m3_out_data), .mux_out_chan(m3_out_chan), .mux_out_valid(m3_out_valid),
    .mux_out_ready(m3_out_ready),
    .demux_in_data(d3_in_data), .demux_in_sel(d3_in_sel), .demux_in_valid(d3_in_valid),
    .demux_in_ready(d3_in_ready), .demux_out_data(d3_out_data), .demux_out_valid(d3_out_valid),
    .demux_out_ready(d3_out_ready), .demux_err(d3_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    m4_in_valid = '1; m3_in_valid = '1; d4_in_valid = 1'b1; d3_in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({m4_out_valid, m4_out_data, m4_out_chan, m4_in_ready, d4_in_ready, d4_out_valid,
           d4_out_data, d4_err} !== '0) begin
        failures++;
        $display("FAIL reset4 cycle %0d: got %0h required 0", c,
                 {m4_out_valid, m4_out_data, m4_out_chan, m4_in_ready, d4_in_ready,
                  d4_out_valid, d4_out_data, d4_err});
      end
      checks++;
      if ({m3_out_valid, m3_out_data, m3_out_chan, m3_in_ready, d3_in_ready, d3_out_valid,
           d3_out_data, d3_err} !== '0) begin
        failures++;
        $display("FAIL reset3 cycle %0d: got %0h required 0", c,
                 {m3_out_valid, m3_out_data, m3_out_chan, m3_in_ready, d3_in_ready,
                  d3_out_valid, d3_out_data, d3_err});
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (m4_in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL first_grant4: got %b required 0001", m4_in_ready);
    end
    checks++;
    if (m3_in_ready !== 3'b001) begin
      failures++;
      $display("FAIL first_grant3: got %b required 001", m3_in_ready);
    end
    m4_in_valid = '0; m3_in_valid = '0; d4_in_valid = 1'b0; d3_in_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    exp_t e;
    for (int i = 0; i < 4; i++) m4_in_data[i*32 +: 32] = 32'(32'hA0 + i);
    m4_out_ready = 1'b1;
    m4_in_valid  = 4'b1111;
    for (int i = 0; i < 5; i++) mux_q.push_back('{data: 32'(32'hA0 + (i % 4)), tag: 4'(i % 4)});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) m4_in_valid = '0;
      e = mux_q.pop_front();
      checks++;
      if ({m4_out_valid, m4_out_chan, m4_out_data} !== {1'b1, e.tag[1:0], e.data}) begin
        failures++;
        $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%0h required v=1 ch=%0d d=%0h", c,
                 m4_out_valid, m4_out_chan, m4_out_data, e.tag, e.data);
      end
    end
  endtask

  task automatic test_sparse_backpressure();
    exp_t e;
    @(negedge clk);
    m4_in_data[1*32 +: 32] = 32'hB1;
    m4_in_data[3*32 +: 32] = 32'hB3;
    m4_in_valid  = 4'b1010;
    m4_out_ready = 1'b0;
    mux_q.push_back('{data: 32'hB1, tag: 4'd1});
    mux_q.push_back('{data: 32'hB3, tag: 4'd3});
    mux_q.push_back('{data: 32'hB1, tag: 4'd1});
    #1;
    checks++;
    if (m4_in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL sparse_grant: got %b required 0010", m4_in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = mux_q[0];
      checks++;
      if ({m4_out_valid, m4_out_chan, m4_out_data, m4_in_ready} !==
          {1'b1, e.tag[1:0], e.data, 4'b0000}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%0h rdy=%b required v=1 ch=%0d d=%0h rdy=0000",
                 c, m4_out_valid, m4_out_chan, m4_out_data, m4_in_ready, e.tag, e.data);
      end
    end
    m4_out_ready = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      e = mux_q.pop_front();
      checks++;
      if ({m4_out_valid, m4_out_chan, m4_out_data} !== {1'b1, e.tag[1:0], e.data}) begin
        failures++;
        $display("FAIL sparse_out[%0d]: got v=%b ch=%0d d=%0h required v=1 ch=%0d d=%0h", c,
                 m4_out_valid, m4_out_chan, m4_out_data, e.tag, e.data);
      end
    end
    m4_in_valid = '0;
  endtask

  task automatic test_non_pow2();
    exp_t e;
    for (int i = 0; i < 3; i++) m3_in_data[i*32 +: 32] = 32'(32'hC0 + i);
    m3_out_ready = 1'b1;
    m3_in_valid  = 3'b111;
    for (int i = 0; i < 4; i++) mux_q.push_back('{data: 32'(32'hC0 + (i % 3)), tag: 4'(i % 3)});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) m3_in_valid = '0;
      e = mux_q.pop_front();
      checks++;
      if ({m3_out_valid, m3_out_chan, m3_out_data} !== {1'b1, e.tag[1:0], e.data}) begin
        failures++;
        $display("FAIL np2_out[%0d]: got v=%b ch=%0d d=%0h required v=1 ch=%0d d=%0h", c,
                 m3_out_valid, m3_out_chan, m3_out_data, e.tag, e.data);
      end
    end
  endtask

  task automatic test_demux_routing();
    exp_t e;
    @(negedge clk);
    d4_out_ready = 4'b0001;
    d4_in_data = 32'h11; d4_in_sel = 2'd2; d4_in_valid = 1'b1;
    dmx_q.push_back('{data: 32'h11, tag: 4'b0100});
    dmx_q.push_back('{data: 32'h22, tag: 4'b0001});
    #1;
    checks++;
    if (d4_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL dmx_ready_idle: got %b required 1", d4_in_ready);
    end
    @(negedge clk);
    d4_in_data = 32'h22; d4_in_sel = 2'd0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      e = dmx_q[0];
      checks++;
      if ({d4_out_valid, d4_out_data, d4_in_ready} !== {e.tag, {4{e.data}}, 1'b0}) begin
        failures++;
        $display("FAIL dmx_stall[%0d]: got v=%b d=%0h rdy=%b required v=%b d=%0h rdy=0", c,
                 d4_out_valid, d4_out_data, d4_in_ready, e.tag, {4{e.data}});
      end
    end
    d4_out_ready = 4'b1111;
    #1;
    e = dmx_q.pop_front();
    checks++;
    if ({d4_out_valid, d4_out_data, d4_in_ready} !== {e.tag, {4{e.data}}, 1'b1}) begin
      failures++;
      $display("FAIL dmx_drain_fill: got v=%b d=%0h rdy=%b required v=%b d=%0h rdy=1",
               d4_out_valid, d4_out_data, d4_in_ready, e.tag, {4{e.data}});
    end
    @(negedge clk);
    d4_in_valid = 1'b0;
    #1;
    e = dmx_q.pop_front();
    checks++;
    if ({d4_out_valid, d4_out_data} !== {e.tag, {4{e.data}}}) begin
      failures++;
      $display("FAIL dmx_second: got v=%b d=%0h required v=%b d=%0h",
               d4_out_valid, d4_out_data, e.tag, {4{e.data}});
    end
    @(negedge clk);
    checks++;
    if (d4_out_valid !== 4'b0000 || dmx_q.size() != 0) begin
      failures++;
      $display("FAIL dmx_no_dup: got v=%b pending=%0d required v=0000 pending=0",
               d4_out_valid, dmx_q.size());
    end
  endtask

  task automatic test_demux_error();
    @(negedge clk);
    d3_out_ready = 3'b111;
    d3_in_data = 32'h33; d3_in_sel = 2'd3; d3_in_valid = 1'b1;
    #1;
    checks++;
    if ({d3_in_ready, d3_err} !== 2'b10) begin
      failures++;
      $display("FAIL err_accept: got rdy=%b err=%b required rdy=1 err=0", d3_in_ready, d3_err);
    end
    @(negedge clk);
    d3_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if ({d3_err, d3_out_valid} !== 4'b1000) begin
        failures++;
        $display("FAIL err_sticky[%0d]: got err=%b v=%b required err=1 v=000", c, d3_err,
                 d3_out_valid);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (d3_err !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared: got %b required 0", d3_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    m4_in_data = '0; m4_in_valid = '0; m4_out_ready = 1'b1;
    d4_in_data = '0; d4_in_sel = '0; d4_in_valid = 1'b0; d4_out_ready = '1;
    m3_in_data = '0; m3_in_valid = '0; m3_out_ready = 1'b1;
    d3_in_data = '0; d3_in_sel = '0; d3_in_valid = 1'b0; d3_out_ready = '1;
    test_reset();
    test_round_robin();
    test_sparse_backpressure();
    test_non_pow2();
    test_demux_routing();
    test_demux_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
